icache_assoc: RTL and testbench

- Parametrised N-way set-associative instruction cache. Successor to the direct-mapped ICache used in the current instruction-fetch path.
- Sits between the core fetch stage and a variable-latency instruction memory.
- Adds associativity with pseudo-LRU replacement, multi-word lines, a ready/ack memory handshake in place of the combinational ROM port, and a flush input.

---
 rtl/icache_assoc.sv | 151 +++++++++++++++
 tb/tb_icache_assoc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with tree-PLRU replacement,
// multi-word line fill over a ready/ack memory port, and a whole-cache flush.
module icache_assoc #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_hit,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_ack
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - OW - IW;
    localparam int LW = $clog2(WAYS);
    localparam int WW = (WAYS > 1) ? LW : 1;
    localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {IDLE, FILL, UPDATE, FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [TW-1:0]         ltag_q;
    logic [IW-1:0]         lidx_q;
    logic [WW-1:0]         victim_q;
    logic [OW-1:0]         k_q;
    logic [SETS-1:0]       valid_q [WAYS];
    logic [PW-1:0]         plru_q  [SETS];
    logic [TW-1:0]         tag_q   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS*LINE_WORDS];

    logic [OW-1:0] off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit_any, inv_found, lookup, miss;
    logic [WW-1:0] hit_way, inv_way, victim;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 1 points the victim right.
    function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] t);
        int n;
        n = 0;
        for (int l = 0; l < LW; l++) n = 2 * n + 1 + int'(t[n]);
        return WW'(n - (WAYS - 1));
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WW-1:0] w);
        logic [PW-1:0] r;
        int n, p;
        r = t;
        n = int'(w) + WAYS - 1;
        for (int l = 0; l < LW; l++) begin
            p = (n - 1) / 2;
            r[p] = (n == 2 * p + 1);
            n = p;
        end
        return r;
    endfunction

    assign off = i_addr[OW-1:0];
    assign idx = i_addr[OW+IW-1:OW];
    assign tag = i_addr[ADDR_WIDTH-1:OW+IW];

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
            if (!inv_found && !valid_q[w][idx]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    assign victim     = inv_found ? inv_way : plru_victim(plru_q[idx]);
    assign lookup     = state_q == IDLE && i_rd && !i_flush;
    assign miss       = lookup && !hit_any;
    assign o_hit      = lookup && hit_any;
    assign o_inst     = o_hit ? data_q[hit_way][{idx, off}] : '0;
    assign o_busy     = state_q != IDLE || miss;
    assign o_mem_rd   = state_q == FILL;
    assign o_mem_addr = o_mem_rd ? {ltag_q, lidx_q, k_q} : '0;

    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        case (state_q)
            IDLE:   state_d = i_flush ? FLUSH : miss ? FILL : IDLE;
            FILL: begin
                pend_d  = pend_q | i_flush;
                state_d = (i_mem_ack && &k_q) ? UPDATE : FILL;
            end
            UPDATE: state_d = (pend_q || i_flush) ? FLUSH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            ltag_q   <= '0;
            lidx_q   <= '0;
            victim_q <= '0;
            k_q      <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (miss) begin
                ltag_q   <= tag;
                lidx_q   <= idx;
                victim_q <= victim;
                k_q      <= '0;
            end
            if (o_hit) plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            if (state_q == FILL && i_mem_ack) k_q <= k_q + 1'b1;
            if (state_q == UPDATE) begin
                valid_q[victim_q][lidx_q] <= 1'b1;
                plru_q[lidx_q]            <= plru_touch(plru_q[lidx_q], victim_q);
            end
            // Entering FLUSH overrides the UPDATE write so a pending flush drops the new line too.
            if (state_d == FLUSH) begin
                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (state_q == FILL && i_mem_ack) data_q[victim_q][{lidx_q, k_q}] <= i_mem_data;
        if (state_q == UPDATE) tag_q[victim_q][lidx_q] <= ltag_q;
    end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: randomized scoreboard bench for icache_assoc against an LRU-list
// model of each set, with a latency-programmable memory responder.
module tb_icache_assoc;
    logic        clk, rst, rd, flush, mem_ack, hit, busy, mem_rd;
    logic [31:0] addr, inst, mem_addr, mem_data;

    icache_assoc dut (
        .i_clock(clk), .i_reset(rst), .i_addr(addr), .i_rd(rd), .i_flush(flush),
        .o_inst(inst), .o_hit(hit), .o_busy(busy), .o_mem_addr(mem_addr),
        .o_mem_rd(mem_rd), .i_mem_data(mem_data), .i_mem_ack(mem_ack)
    );

    typedef struct { logic [31:0] data; bit miss; int busy; } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int lat = 2, late_acks = 0;
    logic [31:0] cur_line = 0;
    logic [1:0]  wcnt = 0;
    logic [31:0] mline [16][2];
    int          mcnt  [16];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Each set holds up to two lines, most-recently-used first.
    task automatic model_access(input logic [31:0] a, output bit m);
        logic [31:0] ln;
        int s;
        ln = a >> 2;
        s  = int'(ln[3:0]);
        m  = 0;
        if (mcnt[s] > 0 && mline[s][0] == ln) m = 0;
        else if (mcnt[s] > 1 && mline[s][1] == ln) begin
            mline[s][1] = mline[s][0];
            mline[s][0] = ln;
        end else begin
            m = 1;
            mline[s][1] = mline[s][0];
            mline[s][0] = ln;
            if (mcnt[s] < 2) mcnt[s]++;
        end
    endtask

    function automatic bit model_has(input logic [31:0] a);
        logic [31:0] ln;
        int s;
        ln = a >> 2;
        s  = int'(ln[3:0]);
        return (mcnt[s] > 0 && mline[s][0] == ln) || (mcnt[s] > 1 && mline[s][1] == ln);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 16; s++) mcnt[s] = 0;
    endtask

    initial begin
        int cnt;
        bit rd_seen;
        cnt = 0;
        rd_seen = 0;
        mem_ack = 0;
        mem_data = 0;
        forever begin
            @(negedge clk);
            cnt = (mem_ack || !rd_seen) ? 0 : cnt + 1;
            rd_seen = mem_rd;
            if (late_acks > 0) begin
                mem_ack = 1;
                mem_data = 32'hDEAD_BEEF;
                late_acks--;
            end else begin
                mem_ack = mem_rd && cnt >= lat - 1;
                mem_data = mem_addr ^ 32'hA5A5_0000;
                if (mem_ack) begin
                    chk("fill_addr", mem_addr, {cur_line[29:0], wcnt});
                    wcnt++;
                end
            end
        end
    end

    initial begin
        int bcnt;
        exp_t e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
                continue;
            end
            if (rd && busy) bcnt++;
            if (hit) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_hit addr=%h inst=%h required=no hit", addr, inst);
                end else begin
                    e = sb.pop_front();
                    chk("inst", inst, e.data);
                    chk("miss", 32'(bcnt > 0), 32'(e.miss));
                    chk("hit_mem_rd", 32'(mem_rd), 0);
                    if (e.busy >= 0) chk("busy_cycles", bcnt, e.busy);
                end
                bcnt = 0;
            end
        end
    end

    // mode 0: plain fetch; 1: flush on the 2nd FILL cycle; 2: flush together with the lookup.
    task automatic fetch(input logic [31:0] a, input int ln, input int mode);
        bit m, got;
        int pen;
        pen = 2 + 4 * ln;
        if (mode == 2) model_clear();
        model_access(a, m);
        if (mode == 1) begin
            model_clear();
            model_access(a, m);
        end
        lat = ln;
        cur_line = a >> 2;
        wcnt = 0;
        sb.push_back('{data: a ^ 32'hA5A5_0000, miss: m,
                       busy: mode == 1 ? 2 * pen + 1 : mode == 2 ? pen + 1 : (m ? pen : 0)});
        addr = a;
        rd = 1;
        if (mode == 2) begin
            flush = 1;
            @(posedge clk);
            #1 flush = 0;
        end
        if (mode == 1) begin
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                got = mem_rd;
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL fill_start_timeout addr=%h mem_rd=0 required=1", a);
            end
            @(posedge clk);
            #1 flush = 1;
            @(posedge clk);
            #1 flush = 0;
        end
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = hit;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL hit_timeout addr=%h hit=0 required=1", a);
            sb.delete();
        end
        @(posedge clk);
        #1 rd = 0;
    endtask

    task automatic flush_cycle();
        int b;
        flush = 1;
        @(negedge clk);
        b = int'(busy);
        @(posedge clk);
        #1 flush = 0;
        repeat (3) begin
            @(negedge clk);
            b += int'(busy);
        end
        chk("flush_busy", b, 1);
        model_clear();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        int r;
        rst = 1;
        rd = 0;
        flush = 0;
        addr = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst", inst, 0);
        @(posedge clk);
        #1;
        fetch(32'h40, 2, 0);
        fetch(32'h43, 2, 0);
        fetch(32'h80, 2, 0);
        fetch(32'h40, 2, 0);
        fetch(32'hC0, 2, 0);
        fetch(32'h40, 2, 0);
        fetch(32'hC0, 2, 0);
        fetch(32'h80, 2, 0);
        fetch(32'h40, 2, 0);
        flush_cycle();
        fetch(32'h40, 2, 0);
        fetch(32'h80, 2, 0);
        flush_cycle();
        fetch(32'h40, 2, 1);
        fetch(32'h40, 2, 2);
        lat = 2;
        cur_line = 32'h100 >> 2;
        wcnt = 0;
        addr = 32'h100;
        rd = 1;
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge clk);
            #1 if (mem_ack) n++;
        end
        @(posedge clk);
        #1 rst = 1;
        rd = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_fill_busy", 32'(busy), 0);
        chk("rst_fill_mem_rd", 32'(mem_rd), 0);
        late_acks = 2;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        fetch(32'h40, 2, 0);
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) ? 32'h1234_5600 : 32'h0) | 32'($urandom_range(0, 255));
            if (r == 0) flush_cycle();
            else fetch(a, $urandom_range(1, 3), (r == 1 && !model_has(a)) ? 1 : (r == 2) ? 2 : 0);
        end
        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
